// File: rtl/dmem_pkg.sv
// Shared widths, FSM state encoding and word/byte helper for the data memory responder.
package dmem_pkg;

    localparam int WORD_W     = 19;
    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        RESP  = 3'd4
    } dmem_state_e;

    // Little-endian byte lane of a 19-bit word; the top lane carries only bits 18:16.
    function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] word,
                                                    input logic [1:0]        lane);
        logic [BYTE_W-1:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            default: b = {5'b0, word[18:16]};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// DEPTH x 8 single-port RAM: synchronous write, registered one-cycle read.
module dmem_byte_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [BYTE_W-1:0] wdata,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [BYTE_W-1:0] rdata_q;

    // Write the addressed byte when enabled and register the addressed byte for the next cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Request/response front end that splits 1- or 3-byte accesses into per-byte RAM cycles.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic              req_word,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata
);

    dmem_state_e       state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              write_q, write_d;
    logic              word_q, word_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [BYTE_W-1:0] b0_q, b0_d;
    logic [BYTE_W-1:0] b1_q, b1_d;

    logic              ram_we;
    logic [AW-1:0]     ram_idx;
    logic [BYTE_W-1:0] ram_wdata;
    logic [BYTE_W-1:0] ram_rdata;
    logic [1:0]        last_cnt;

    // Truncating the sum to AW bits gives the modulo-DEPTH wrap of the byte index.
    assign ram_idx   = AW'(addr_q + WORD_W'(cnt_q));
    assign ram_wdata = word_byte(wdata_q, cnt_q);
    assign last_cnt  = word_q ? 2'(WORD_BYTES - 1) : 2'd0;

    dmem_byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Next-state, byte sequencing, capture of the request and assembly of load data.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        write_d = write_q;
        word_d  = word_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        ram_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    word_d  = req_word;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 2'd0;
                    rdata_d = '0;
                    state_d = req_write ? WRITE : READ;
                end
            end
            WRITE: begin
                // A reset landing mid-store must not commit the byte of that cycle.
                ram_we = reset;
                if (cnt_q == last_cnt) begin
                    cnt_d   = 2'd0;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            READ: begin
                // The RAM output now holds the byte addressed in the previous cycle.
                if (cnt_q == 2'd1) b0_d = ram_rdata;
                if (cnt_q == 2'd2) b1_d = ram_rdata;
                if (cnt_q == last_cnt) begin
                    cnt_d   = 2'd0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DRAIN: begin
                rdata_d = word_q ? {ram_rdata[2:0], b1_q, b0_q} : {11'b0, ram_rdata};
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and response data, cleared by the active-low synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Captured request fields and partial load bytes carry no reset.
    always_ff @(posedge clk) begin
        write_q <= write_d;
        word_q  <= word_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        b0_q    <= b0_d;
        b1_q    <= b1_d;
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 1024, byte capacity of the data memory; SHALL be a power of two.
REQ-002 Parameter AW, default $clog2(DEPTH), width of the internal byte index.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  1  access request present.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  19  byte address; the value the memory stage issues as its ALU result.
REQ-009 req_wdata  input  19  store data.
REQ-010 req_word  input  1  access size (Cant_Byte): 0 = 1 byte, 1 = 3-byte word.
REQ-011 rsp_valid  output  1  access complete; response data valid.
REQ-012 rsp_ready  input  1  consumer accepts the response.
REQ-013 rsp_rdata  output  19  load result; 0 for stores.

Function
REQ-014 Request SHALL be accepted on an edge where req_valid && req_ready; req_write, req_addr, req_wdata and req_word SHALL be captured only at that edge.
REQ-015 req_ready SHALL be 1 only in IDLE; inputs outside acceptance are ignored.
REQ-016 FSM states: IDLE, WRITE, READ, DRAIN, RESP.
REQ-017 IDLE -> WRITE on accepted store; IDLE -> READ on accepted load.
REQ-018 Byte count N = 1 when req_word = 0, N = 3 when req_word = 1; a byte counter SHALL sequence bytes 0..N-1.
REQ-019 Byte i SHALL use index (req_addr + i) mod DEPTH; the index wraps from DEPTH-1 to 0.
REQ-020 Word layout SHALL be little-endian: byte0 = wdata[7:0], byte1 = wdata[15:8], byte2 = {5'b0, wdata[18:16]}.
REQ-021 WRITE SHALL commit one byte per cycle for N cycles, then go to RESP.
REQ-022 A byte store SHALL write wdata[7:0] only.
REQ-023 READ SHALL present one byte index per cycle for N cycles.
REQ-024 DRAIN (1 cycle) SHALL capture the last RAM output, then go to RESP.
REQ-025 Byte load SHALL return {11'b0, byte0}; word load SHALL return {byte2[2:0], byte1, byte0}.
REQ-026 Latency, in edges from the accepting edge to rsp_valid = 1: byte store 2, word store 4, byte load 3, word load 5.
REQ-027 RESP: rsp_valid = 1; rsp_rdata SHALL be held stable until the rsp_valid && rsp_ready edge, then go to IDLE.
REQ-028 Response handshake: a request SHALL NOT be accepted in the cycle the response completes; the next acceptance is possible one cycle later, in IDLE.
REQ-029 Stalled rsp_ready SHALL hold the FSM in RESP indefinitely with outputs unchanged.

Reset
REQ-030 While reset = 0 at an edge: state = IDLE, counter = 0, rsp_valid = 0, rsp_rdata = 0, req_ready = 1 from the following cycle.
REQ-031 Reset mid-operation SHALL abort the access: bytes already committed remain; uncommitted bytes are not written; no response is issued.
REQ-032 Reset SHALL NOT clear memory contents.

Structure
REQ-033 The shared package dmem_pkg SHALL hold WORD_W = 19, BYTE_W = 8, WORD_BYTES = 3 and the FSM state enum.
REQ-034 The single sub-module dmem_byte_ram SHALL be a DEPTH x 8 single-port RAM with synchronous write and registered (1-cycle) read.

Verification
REQ-035 Byte store 0x03 at 0x5, then byte load 0x5 -> rsp_rdata = 0x00003; store response rdata = 0; latencies 2 and 3.
REQ-036 Word store 0x7ABCD at 0x10, then word load 0x10 -> 0x7ABCD; byte load 0x12 -> 0x00007; byte load 0x11 -> 0x000AB.
REQ-037 Wrap: DEPTH = 1024, word store 0x12345 at 0x3FF -> byte loads return 0x45 at 0x3FF, 0x23 at 0x000, 0x01 at 0x001.
REQ-038 Back-pressure: word load with rsp_ready = 0 for 3 cycles -> rsp_valid and rsp_rdata held stable, req_ready = 0, and a new req_valid is not accepted until IDLE.
REQ-039 Prefill 0x000000 at 0x20, then word store 0x7FFFF at 0x20 with reset asserted 2 cycles after acceptance -> rsp_valid = 0, no response; reload shows 0xFF at 0x20 and 0x00 at 0x22.
REQ-040 Size decode: byte store 0x7ABCD at 0x30 over prefilled 0x11 bytes -> only 0x30 changes (0xCD); 0x31 and 0x32 stay 0x11.
